// File: rtl/tank_pkg.sv
// Shared constants, encodings and FSM state type for the object sweep engine.
package tank_pkg;

    // storage slot selects
    localparam logic [3:0] MODE_T1 = 4'b0001;
    localparam logic [3:0] MODE_T2 = 4'b0011;
    localparam logic [3:0] MODE_P1 = 4'b0101;
    localparam logic [3:0] MODE_P2 = 4'b0111;

    // headings: up is y-1 because y=0 is the top row
    localparam logic [1:0] HD_UP    = 2'b00;
    localparam logic [1:0] HD_RIGHT = 2'b01;
    localparam logic [1:0] HD_DOWN  = 2'b10;
    localparam logic [1:0] HD_LEFT  = 2'b11;

    // pos = {y, x}
    localparam int COORD_W  = 4;
    localparam int POS_W    = 2 * COORD_W;
    localparam int GRID_MAX = 15;

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, CALC, WRITE, DONE
    } state_t;

    // slot 0..3 maps onto the odd mode codes T1, T2, P1, P2
    function automatic logic [3:0] slot_mode(input logic [1:0] slot);
        return {1'b0, slot, 1'b1};
    endfunction

endpackage

// File: rtl/object_updater_if.sv
// Storage-side bus: slot select, read/write strobes, write data and read data.
interface object_updater_if;
    logic [3:0] st_mode;
    logic [7:0] st_address;
    logic [7:0] st_data;
    logic       st_wren;
    logic       st_load_out;
    logic [7:0] st_pos;
    logic [7:0] st_dir;

    modport master (output st_mode, st_address, st_data, st_wren, st_load_out,
                    input  st_pos, st_dir);
    modport slave  (input  st_mode, st_address, st_data, st_wren, st_load_out,
                    output st_pos, st_dir);
endinterface

// File: rtl/object_updater_pos_step.sv
// One-cell move on the 16x16 grid; a move past an edge reports off_grid and keeps pos.
module pos_step
    import tank_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic [1:0]       heading,
    output logic [POS_W-1:0] next_pos,
    output logic             off_grid
);
    logic [COORD_W-1:0] x, y;
    localparam logic [COORD_W-1:0] EDGE = COORD_W'(GRID_MAX);

    assign x = pos[COORD_W-1:0];
    assign y = pos[POS_W-1:COORD_W];

    // step along heading, clamp at the border
    always_comb begin
        next_pos = pos;
        off_grid = 1'b0;
        case (heading)
            HD_UP:    if (y == '0)   off_grid = 1'b1; else next_pos = {y - 1'b1, x};
            HD_RIGHT: if (x == EDGE) off_grid = 1'b1; else next_pos = {y, x + 1'b1};
            HD_DOWN:  if (y == EDGE) off_grid = 1'b1; else next_pos = {y + 1'b1, x};
            default:  if (x == '0)   off_grid = 1'b1; else next_pos = {y, x - 1'b1};
        endcase
    end
endmodule

// File: rtl/object_updater.sv
// Per-tick sweep over tank/projectile slots: read from storage, compute next state, write back.
module object_updater
    import tank_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [2:0]              p1_cmd,
    input  logic [2:0]              p2_cmd,
    input  logic [1:0]              fire,
    object_updater_if.master        st,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              hit
);
    state_t state, state_n;
    logic [1:0] slot, slot_n, wait_cnt;
    logic       wait_last;
    logic [7:0] rd_pos;
    logic [2:0] rd_dir;
    logic [1:0][7:0] tank_pos;
    logic [1:0][1:0] tank_hd;
    logic [1:0] fire_q, hit_q, hit_set;
    logic [7:0] calc_pos, calc_dir, step_pos;
    logic [2:0] cmd;
    logic [1:0] step_hd;
    logic       is_tank, idx, opp, step_off, fire_pend;
    logic       unused_dir_hi;

    assign unused_dir_hi = ^st.st_dir[7:3];
    assign wait_last = (wait_cnt == 2'(READ_LAT - 1));
    assign is_tank   = ~slot[1];
    assign idx       = slot[0];
    assign opp       = ~slot[0];
    assign cmd       = idx ? p2_cmd : p1_cmd;
    assign fire_pend = fire_q[idx] | fire[idx];
    // tanks step along the commanded heading, projectiles along their own
    assign step_hd   = is_tank ? cmd[1:0] : rd_dir[1:0];

    pos_step u_step (
        .pos      (rd_pos),
        .heading  (step_hd),
        .next_pos (step_pos),
        .off_grid (step_off)
    );

    // next-state and slot sequencing
    always_comb begin
        state_n = state;
        slot_n  = slot;
        case (state)
            IDLE:  if (tick) begin state_n = READ; slot_n = 2'd0; end
            READ:  state_n = WAIT;
            WAIT:  if (wait_last) state_n = CALC;
            CALC:  state_n = WRITE;
            WRITE: if (slot == 2'd3) state_n = DONE;
                   else begin state_n = READ; slot_n = slot + 2'd1; end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // movement, collision and spawn rules for the slot in CALC
    always_comb begin
        calc_pos = rd_pos;
        calc_dir = {5'b0, rd_dir};
        hit_set  = 2'b00;
        if (is_tank) begin
            if (cmd[2]) begin
                calc_pos = step_pos;
                calc_dir = {5'b0, 1'b1, cmd[1:0]};
            end
        end else if (rd_dir[2]) begin
            if (step_off) begin
                calc_dir[2] = 1'b0;
            end else begin
                calc_pos = step_pos;
                if (step_pos == tank_pos[opp]) begin
                    calc_dir[2]  = 1'b0;
                    hit_set[opp] = 1'b1;
                end
            end
        end else if (fire_pend) begin
            calc_pos = tank_pos[idx];
            calc_dir = {5'b0, 1'b1, tank_hd[idx]};
            if (tank_pos[idx] == tank_pos[opp]) hit_set[opp] = 1'b1;
        end
    end

    // FSM state, slot counter and read-latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            slot     <= 2'd0;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
        end
    end

    // read capture, tank capture, fire latches and pending hits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pos   <= '0;
            rd_dir   <= '0;
            tank_pos <= '0;
            tank_hd  <= '0;
            fire_q   <= '0;
            hit_q    <= '0;
        end else begin
            if (state == WAIT && wait_last) begin
                rd_pos <= st.st_pos;
                rd_dir <= st.st_dir[2:0];
            end
            if (state == CALC && is_tank) begin
                tank_pos[idx] <= calc_pos;
                tank_hd[idx]  <= calc_dir[1:0];
            end
            // a projectile's CALC consumes its latch, including a same-cycle pulse
            for (int i = 0; i < 2; i++) begin
                if (state == CALC && !is_tank && idx == 1'(i)) fire_q[i] <= 1'b0;
                else if (fire[i])                                fire_q[i] <= 1'b1;
            end
            if (state == IDLE && tick) hit_q <= 2'b00;
            else if (state == CALC)    hit_q <= hit_q | hit_set;
        end
    end

    // registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st.st_mode     <= '0;
            st.st_address  <= '0;
            st.st_data     <= '0;
            st.st_wren     <= 1'b0;
            st.st_load_out <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            hit            <= 2'b00;
        end else begin
            st.st_mode     <= (state_n inside {READ, WAIT, CALC, WRITE}) ? slot_mode(slot_n) : 4'b0;
            st.st_address  <= (state_n == WRITE) ? calc_pos : 8'h00;
            st.st_data     <= (state_n == WRITE) ? calc_dir : 8'h00;
            st.st_wren     <= (state_n == WRITE);
            st.st_load_out <= (state_n == READ);
            busy           <= (state_n != IDLE);
            done           <= (state_n == DONE);
            hit            <= (state_n == DONE) ? hit_q : 2'b00;
        end
    end
endmodule

// File: tb/tb_object_updater.sv
// Bench for object_updater: storage model, reference sweep model feeding a write/hit scoreboard.
module tb_object_updater;
    import tank_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] p1_cmd = 3'b0, p2_cmd = 3'b0;
    logic [1:0] fire = 2'b0;
    logic       busy, done;
    logic [1:0] hit;

    object_updater_if bus ();

    object_updater #(.READ_LAT(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .p1_cmd (p1_cmd),
        .p2_cmd (p2_cmd),
        .fire   (fire),
        .st     (bus),
        .busy   (busy),
        .done   (done),
        .hit    (hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // storage model: 1-cycle read latency, preload port for the bench
    logic [7:0] mem_pos [4];
    logic [7:0] mem_dir [4];
    logic       ld_en = 1'b0;
    logic [1:0] ld_slot = 2'd0;
    logic [7:0] ld_pos = 8'h0, ld_dir = 8'h0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem_pos[ld_slot] <= ld_pos;
            mem_dir[ld_slot] <= ld_dir;
        end
        if (bus.st_wren) begin
            mem_pos[bus.st_mode[2:1]] <= bus.st_address;
            mem_dir[bus.st_mode[2:1]] <= bus.st_data;
        end
        if (bus.st_load_out) begin
            bus.st_pos <= mem_pos[bus.st_mode[2:1]];
            bus.st_dir <= mem_dir[bus.st_mode[2:1]];
        end
    end

    // scoreboard
    typedef struct packed { logic [3:0] mode; logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        wq [$];
    logic [1:0] hq [$];
    logic [1:0] last_hit = 2'b00;

    always @(negedge clk) begin
        if (reset) begin
            chk("strobe_excl", 32'(bus.st_wren & bus.st_load_out), 0);
            if (bus.st_wren) begin
                if (wq.size() == 0) chk("wr_unexp", {bus.st_mode, bus.st_address, bus.st_data}, 0);
                else chk("wr", {bus.st_mode, bus.st_address, bus.st_data}, wq.pop_front());
            end
            if (done) begin
                last_hit <= hit;
                if (hq.size() == 0) chk("done_unexp", 32'(done), 0);
                else chk("hit", 32'(hit), 32'(hq.pop_front()));
            end
        end
    end

    // reference model state
    logic [7:0] m_pos [4];
    logic [7:0] m_dir [4];
    logic [1:0] m_fire = 2'b00;

    task automatic mstep(input logic [7:0] p, input logic [1:0] h,
                         output logic [7:0] np, output logic off);
        int x, y;
        x = int'(p[3:0]);
        y = int'(p[7:4]);
        case (h)
            2'd0: y = y - 1;
            2'd1: x = x + 1;
            2'd2: y = y + 1;
            default: x = x - 1;
        endcase
        off = (x < 0 || x > 15 || y < 0 || y > 15);
        np  = off ? p : {4'(y), 4'(x)};
    endtask

    task automatic model_sweep();
        logic [7:0] tp [2];
        logic [1:0] th [2];
        logic [1:0] h = 2'b00;
        for (int s = 0; s < 4; s++) begin
            logic [7:0] p, np;
            logic [2:0] d, c;
            logic       off;
            int         i, o;
            p = m_pos[s];
            d = m_dir[s][2:0];
            if (s < 2) begin
                c = (s == 1) ? p2_cmd : p1_cmd;
                if (c[2]) begin
                    d = {1'b1, c[1:0]};
                    mstep(p, c[1:0], np, off);
                    p = np;
                end
                tp[s] = p;
                th[s] = d[1:0];
            end else begin
                i = s - 2;
                o = 1 - i;
                if (d[2]) begin
                    mstep(p, d[1:0], np, off);
                    if (off) d[2] = 1'b0;
                    else begin
                        p = np;
                        if (p == tp[o]) begin d[2] = 1'b0; h[o] = 1'b1; end
                    end
                    m_fire[i] = 1'b0;
                end else if (m_fire[i]) begin
                    p = tp[i];
                    d = {1'b1, th[i]};
                    m_fire[i] = 1'b0;
                    if (p == tp[o]) h[o] = 1'b1;
                end
            end
            m_pos[s] = p;
            m_dir[s] = {5'b0, d};
            wq.push_back({4'(2 * s + 1), p, {5'b0, d}});
        end
        hq.push_back(h);
    endtask

    task automatic set_slot(input logic [1:0] s, input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        ld_slot = s; ld_pos = p; ld_dir = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        m_pos[s] = p;
        m_dir[s] = d;
    endtask

    task automatic pulse_fire(input logic [1:0] f);
        @(negedge clk);
        fire = f;
        @(negedge clk);
        fire = 2'b00;
        m_fire = m_fire | f;
    endtask

    task automatic do_sweep(input bit extra_tick);
        int n;
        model_sweep();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n = 1;
        chk("busy_c1", 32'(busy), 1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            tick = (extra_tick && n == 5);
        end
        tick = 1'b0;
        chk("done_cyc", n, 17);
        @(negedge clk);
        chk("busy_end", 32'(busy), 0);
        chk("q_empty", wq.size() + hq.size(), 0);
    endtask

    initial begin
        logic [7:0] sv_pos [4];
        logic [7:0] sv_dir [4];

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit",  32'(hit), 0);
        chk("rst_strb", {bus.st_wren, bus.st_load_out}, 0);
        chk("rst_bus",  {bus.st_mode, bus.st_address, bus.st_data}, 0);
        @(negedge clk);
        reset = 1'b1;

        // tank steps right
        set_slot(0, 8'h55, 8'h05);
        set_slot(1, 8'hA0, 8'h04);
        set_slot(2, 8'h00, 8'h00);
        set_slot(3, 8'h00, 8'h00);
        p1_cmd = 3'b101; p2_cmd = 3'b000;
        do_sweep(0);
        chk("t1_right", {mem_pos[0], mem_dir[0]}, 16'h5605);

        // both tanks clamped at the border
        set_slot(0, 8'h5F, 8'h05);
        set_slot(1, 8'h0A, 8'h04);
        p1_cmd = 3'b101; p2_cmd = 3'b100;
        do_sweep(0);
        chk("t1_clamp", {mem_pos[0], mem_dir[0]}, 16'h5F05);
        chk("t2_clamp", {mem_pos[1], mem_dir[1]}, 16'h0A04);

        // spawn from an idle fire, then travel
        set_slot(0, 8'h33, 8'h06);
        p1_cmd = 3'b000; p2_cmd = 3'b000;
        pulse_fire(2'b01);
        do_sweep(0);
        chk("p1_spawn", {mem_pos[2], mem_dir[2]}, 16'h3306);
        do_sweep(0);
        chk("p1_move", {mem_pos[2], mem_dir[2]}, 16'h4306);

        // projectile leaves the grid
        set_slot(2, 8'h2F, 8'h05);
        do_sweep(0);
        chk("p1_edge", {mem_pos[2], mem_dir[2]}, 16'h2F01);
        chk("edge_nohit", 32'(last_hit), 0);

        // projectile walks into T2
        set_slot(1, 8'h88, 8'h04);
        set_slot(2, 8'h87, 8'h05);
        do_sweep(0);
        chk("hit_t2", 32'(last_hit), 32'h2);
        chk("p1_hit", {mem_pos[2], mem_dir[2]}, 16'h8801);

        // reset during WAIT of slot 2 drops the sweep and the pending P2 fire
        pulse_fire(2'b10);
        for (int s = 0; s < 4; s++) begin sv_pos[s] = m_pos[s]; sv_dir[s] = m_dir[s]; end
        p1_cmd = 3'b110;
        model_sweep();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abrt_busy", 32'(busy), 0);
        chk("abrt_strb", {bus.st_wren, bus.st_load_out}, 0);
        chk("abrt_bus",  {bus.st_mode, bus.st_address, bus.st_data}, 0);
        for (int s = 2; s < 4; s++) begin m_pos[s] = sv_pos[s]; m_dir[s] = sv_dir[s]; end
        m_fire = 2'b00;
        wq.delete();
        hq.delete();
        @(negedge clk);
        reset = 1'b1;
        chk("abrt_t1_kept", {mem_pos[0], mem_dir[0]}, {m_pos[0], m_dir[0]});
        p1_cmd = 3'b000;
        do_sweep(1);
        chk("p2_no_spawn", mem_dir[3], 8'h00);

        // random commands and fires
        for (int k = 0; k < 6; k++) begin
            p1_cmd = 3'($urandom);
            p2_cmd = 3'($urandom);
            if (k % 2 == 0) pulse_fire(2'($urandom));
            do_sweep(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/object_updater.md
# object_updater

Per-game-tick sweep engine directly upstream and downstream of `storage`. On each `tick` it walks the four object slots (tank 1, tank 2, projectile 1, projectile 2), reads each slot's position and direction from `storage`, computes the next state from player commands and movement rules, and writes the result back. It also raises projectile-on-tank hit pulses for the scoring logic.

## Interface
- `READ_LAT`, 1: cycles from `st_load_out` assertion to valid `st_pos`/`st_dir`; legal range 1–3.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle sweep request.
- `p1_cmd`, `p2_cmd`  in  3 each  `{move, heading[1:0]}` per player; level, sampled in that tank's CALC cycle.
- `fire`  in  2  per-player fire pulse; `[0]` is P1, `[1]` is P2.
- `st_mode`  out  4  slot select: 0001 T1, 0011 T2, 0101 P1-projectile, 0111 P2-projectile.
- `st_address`  out  8  position written to `storage`.
- `st_data`  out  8  direction written to `storage`.
- `st_wren`  out  1  write strobe.
- `st_load_out`  out  1  read strobe.
- `st_pos`, `st_dir`  in  8 each  read data from `storage`.
- `busy`  out  1  high from READ of slot 0 through DONE.
- `done`  out  1  one-cycle pulse at sweep end.
- `hit`  out  2  one-cycle pulse in DONE; bit i means tank i+1 was hit.

## Operation
- Position encoding is `{y[3:0], x[3:0]}` on a 16×16 grid, with y=0 at the top.
- Direction encoding is `dir[2]` = alive and `dir[1:0]` = heading: 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1). `dir[7:3]` is written as 0.
- FSM states: IDLE, READ, WAIT, CALC, WRITE, DONE. Slot order is 0..3 via a 2-bit slot counter.
  - IDLE: a `tick` moves the FSM to READ with slot=0.
  - READ: drives `st_mode` and `st_load_out`=1.
  - WAIT: lasts `READ_LAT` cycles.
  - CALC: registers the new pos/dir.
  - WRITE: drives `st_wren`=1, `st_address`, `st_data`, and keeps `st_mode`. It then goes to READ of the next slot, or to DONE after slot 3.
  - DONE: moves to IDLE.
- Tank slot:
  - `move`=0: pos/dir written back unchanged.
  - `move`=1: heading ← cmd heading and alive ← 1. Pos steps one cell; a step that would leave the grid clamps, i.e. pos stays put with the new heading.
  - The final tank pos/heading is captured internally for projectile use.
- Projectile slot, alive:
  - Step one cell along its heading.
  - If the step would leave the grid: alive ← 0, pos unchanged.
  - If the stepped pos equals the opposing tank's captured pos: alive ← 0 and set the pending hit bit for that tank.
  - A pending fire for this player is discarded.
- Projectile slot, dead, with fire pending: spawn at the owner tank's captured pos with the owner's heading and alive=1. No step this tick. Clear the pending fire. A spawn onto the opposing tank's cell counts as a hit.
- Projectile slot, dead, no fire pending: written back unchanged.
- Fire latches:
  - Set on a `fire[i]` pulse in any state.
  - A pulse coinciding with that projectile's CALC cycle is consumed, i.e. same-cycle set and consume leaves the latch clear.
- `tick` while `busy` is ignored and not queued.
- Reset, asserted at any time including mid-sweep:
  - State → IDLE, slot → 0; fire latches, hit bits and captured tank data cleared.
  - All outputs 0 on reset.
  - A partially completed sweep is abandoned; slots already written keep their new values.

## Timing
- All outputs are registered.
- `tick` is sampled at edge 0. READ slot 0 is cycle 1.
- Each slot takes 3+`READ_LAT` cycles. With `READ_LAT`=1: 16 cycles for four slots, DONE/`done`/`hit` on cycle 17, IDLE on cycle 18, and the next `tick` is accepted at edge 18.
- `st_pos`/`st_dir` are sampled on the final WAIT edge.
- `st_wren` and `st_load_out` are never high in the same cycle.
- At most one strobe per slot of each kind.

## Structure
- Package `tank_pkg` holds:
  - mode constants MODE_T1/T2/P1/P2;
  - heading constants;
  - position field widths, grid max 15;
  - FSM state enum.
- Sub-module `pos_step`, combinational: (pos, heading) → (next_pos, off_grid). It is instantiated once and shared across slots.

## Test plan
- T1 at 0x55 heading right, `p1_cmd`=3'b101, tick → WRITE slot 0 drives `st_address`=0x56, `st_data`=0x05. `done` at cycle 17.
- T1 at x=15 (0x5F) with `p1_cmd`=3'b101 → pos stays 0x5F, dir 0x05. T2 at y=0 with `move` up → clamped likewise.
- `fire[0]` pulse while idle, T1 at 0x33 heading down, P1-projectile dead → projectile written 0x33/0x06. Next tick → 0x43/0x06.
- P1-projectile at 0x2F heading right, alive → written dir 0x01 (dead), pos 0x2F, no `hit`.
- P1-projectile one cell left of T2, heading right → `hit`=2'b10 in DONE, projectile alive cleared.
- Assert `reset` low during WAIT of slot 2 → `busy`/`st_*` go 0 immediately. After release, a second `tick` runs a full 17-cycle sweep; a `tick` during `busy` is ignored.
